// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding and reset constants.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    VALID = 2'd2,
    FAULT = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit_next_pc_sel.sv
// Next-PC selection from controller redirect decisions, with alignment check.
// Purely combinational so a pipelined fetch can reuse it unchanged.
module next_pc_sel #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] instr_pc,
  input  logic            pc_src,
  input  logic            jalr,
  input  logic [XLEN-1:0] pc_target,
  input  logic [XLEN-1:0] alu_result,
  output logic [XLEN-1:0] next_pc,
  output logic            misaligned
);

  // jalr wins over pc_src because the controller raises both for jalr
  always_comb begin
    next_pc = instr_pc + XLEN'(4);
    if (jalr) begin
      next_pc = alu_result & ~XLEN'(1);
    end else if (pc_src) begin
      next_pc = pc_target;
    end
  end

  assign misaligned = |next_pc[1:0];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches from variable-latency memory and
// hands one instruction at a time to decode through a valid/ready handshake.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            imem_rvalid,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] instr_pc,
  output logic [XLEN-1:0] instr_pc_plus4,
  output logic            instr_valid,
  input  logic            instr_ready,
  input  logic            pc_src,
  input  logic            jalr,
  input  logic [XLEN-1:0] pc_target,
  input  logic [XLEN-1:0] alu_result,
  output logic            fault,
  output logic [XLEN-1:0] fault_pc
);

  fetch_state_e    state, state_nxt;
  logic [XLEN-1:0] pc_p0;
  logic [31:0]     instr_p1;
  logic [XLEN-1:0] instr_pc_p1;
  logic            vld_p1;
  logic [XLEN-1:0] fault_pc_r;
  logic [XLEN-1:0] sel_pc;
  logic            sel_mis;
  logic            accept;

  next_pc_sel #(.XLEN(XLEN)) u_next_pc_sel (
    .instr_pc   (instr_pc_p1),
    .pc_src     (pc_src),
    .jalr       (jalr),
    .pc_target  (pc_target),
    .alu_result (alu_result),
    .next_pc    (sel_pc),
    .misaligned (sel_mis)
  );

  assign accept = (state == VALID) && instr_ready;

  always_comb begin
    state_nxt = state;
    imem_req  = 1'b0;
    vld_p1    = 1'b0;
    fault     = 1'b0;
    case (state)
      FETCH: begin
        imem_req  = !reset;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (imem_rvalid) state_nxt = VALID;
      end
      VALID: begin
        vld_p1 = 1'b1;
        if (instr_ready) state_nxt = sel_mis ? FAULT : FETCH;
      end
      FAULT: begin
        fault     = 1'b1;
        state_nxt = FAULT;
      end
      default: state_nxt = FETCH;
    endcase
  end

  // p0 -> p1: memory response registered into the decode-facing instruction slot
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= FETCH;
      pc_p0       <= RESET_PC;
      instr_p1    <= NOP_INSTR;
      instr_pc_p1 <= RESET_PC;
      fault_pc_r  <= '0;
    end else begin
      state <= state_nxt;
      if (state == WAIT && imem_rvalid) begin
        instr_p1    <= imem_rdata;
        instr_pc_p1 <= pc_p0;
      end
      // a misaligned redirect freezes pc and records the bad target instead
      if (accept) begin
        if (sel_mis) fault_pc_r <= sel_pc;
        else         pc_p0      <= sel_pc;
      end
    end
  end

  assign imem_addr      = pc_p0;
  assign instr          = instr_p1;
  assign instr_pc       = instr_pc_p1;
  assign instr_pc_plus4 = instr_pc_p1 + XLEN'(4);
  assign instr_valid    = vld_p1;
  assign fault_pc       = fault_pc_r;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the controller/decoder: owns the PC and fetches from a variable-latency instruction memory.
- Presents one instruction at a time to decode/execute through a valid/ready handshake.
- On acceptance, computes the next PC from the branch/jump decisions the controller returns: PCSrc, jalr, target.
- Flags misaligned fetch targets and halts on them.

Parameters:
- XLEN, 32, datapath and address width.
- RESET_PC, 32'h0000_0000, PC value loaded at reset.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- reset  input  1  reset; synchronous, active-high.
- imem_req  output  1  one-cycle fetch request pulse.
- imem_addr  output  XLEN  fetch address; equals pc.
- imem_rdata  input  32  instruction word returned.
- imem_rvalid  input  1  response valid; arrives ≥1 cycle after imem_req.
- instr  output  32  instruction held for decode.
- instr_pc  output  XLEN  PC of instr.
- instr_pc_plus4  output  XLEN  instr_pc + 4 (link value for jal/jalr).
- instr_valid  output  1  instr/instr_pc are valid.
- instr_ready  input  1  execute stage consumes instr this cycle.
- pc_src  input  1  controller PCSrc, meaning take a branch or jump.
- jalr  input  1  controller jalr; target comes from alu_result.
- pc_target  input  XLEN  instr_pc + ImmExt, from the datapath.
- alu_result  input  XLEN  rs1 + imm, the jalr target.
- fault  output  1  sticky misaligned-target fault.
- fault_pc  output  XLEN  offending target address.

Behaviour:
- All registers update on the rising edge of clk; reset is synchronous and active-high.
- Reset values:
  - state = FETCH, pc = RESET_PC.
  - instr = 32'h0000_0013 (NOP), instr_pc = RESET_PC.
  - instr_valid = 0, fault = 0, fault_pc = 0.
  - imem_req = 0 while reset is high.
- States:
  - FETCH: imem_req = 1 (Moore), imem_addr = pc. Always goes to WAIT next cycle.
  - WAIT: imem_req = 0. On imem_rvalid, capture instr = imem_rdata and instr_pc = pc, set instr_valid = 1, go to VALID. Otherwise stay in WAIT; there is no timeout.
  - VALID: instr_valid = 1 and instr is stable. If instr_ready, compute next_pc, deassert instr_valid, and go to FETCH (or FAULT). If not instr_ready, hold all outputs.
  - FAULT: instr_valid = 0, imem_req = 0, fault = 1. Leaves only on reset.
- next_pc selection, sampled in VALID when instr_ready = 1:
  - jalr = 1: alu_result & ~1. jalr takes priority over pc_src; the controller asserts both for jalr.
  - jalr = 0, pc_src = 1: pc_target.
  - otherwise: instr_pc + 4.
- Misalignment: if next_pc[1:0] != 2'b00 after the jalr bit-0 clear, set fault_pc = next_pc, leave pc unchanged, and go to FAULT.
- Arithmetic: all PC arithmetic is modulo 2^XLEN, so 32'hFFFF_FFFC + 4 wraps to 0 with no error.
- imem_rvalid outside WAIT is ignored. This covers stale responses after a mid-fetch reset.
- instr_ready while instr_valid = 0 is ignored.
- Reset in any state, including WAIT or FAULT, returns to reset values on the next edge. The first imem_req is issued in the first cycle after reset deasserts.
- Latency and throughput:
  - Request to instr_valid = memory latency + 1 cycle (rvalid is registered into instr).
  - Minimum 3 cycles per instruction: FETCH, WAIT with rvalid in the first WAIT cycle, then VALID with instr_ready.
- instr_pc_plus4 is combinational from instr_pc.

Decomposition:
- Shared package holds:
  - State encoding: FETCH = 2'd0, WAIT = 2'd1, VALID = 2'd2, FAULT = 2'd3.
  - NOP_INSTR = 32'h0000_0013.
  - Default RESET_PC.
- One combinational sub-module, next_pc_sel: inputs instr_pc, pc_src, jalr, pc_target, alu_result; outputs next_pc and misaligned. It is reusable by a later pipelined fetch.
- The FSM and registers stay in fetch_unit.

Test Plan:
- Reset then sequential fetch: reset for 2 cycles, memory latency 1, instr_ready = 1, no redirects.
  - imem_addr = 0x0, 0x4, 0x8 on successive FETCH cycles.
  - instr_valid every third cycle.
- Taken branch: instr_pc = 0x10, pc_src = 1, pc_target = 0x40 at accept.
  - Next imem_addr = 0x40, instr_pc_plus4 was 0x14.
- jalr with odd target: jalr = 1, pc_src = 1, alu_result = 0x101.
  - Next fetch at 0x100, fault stays 0.
  - Then alu_result = 0x102: fault = 1, fault_pc = 0x102, no further imem_req.
- Backpressure and variable latency: rvalid 5 cycles after request, instr_ready low for 4 cycles.
  - instr and instr_pc stable throughout; a spurious imem_rvalid during VALID is ignored.
- Reset mid-WAIT: reset asserted in WAIT, rvalid with 0xDEADBEEF arrives the cycle after reset deasserts.
  - instr_valid stays 0, next imem_addr = RESET_PC, 0xDEADBEEF is never presented.
- Wrap: instr_pc = 0xFFFF_FFFC accepted with no redirect.
  - Next imem_addr = 0x0000_0000.
